hilo_muldiv_unit: RTL

//  Iterative multiply/divide unit: the producer side of the HI/LO write interface that the decode stage consumes.

---
 rtl/hilo_muldiv_unit_pkg.sv | 36 +++
 rtl/hilo_muldiv_unit_step.sv | 31 +++
 rtl/hilo_muldiv_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Op codes, FSM states and op-class helpers for the HI/LO multiply/divide unit.
// MULDIV_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package muldiv_info;

    typedef enum logic [2:0] {
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
        MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU
    } md_op_t;

    typedef enum logic [1:0] {IDLE, RUN, FIN} md_state_t;

    function automatic logic is_div(md_op_t op);
        return op inside {MD_DIV, MD_DIVU};
    endfunction

    function automatic logic is_signed(md_op_t op);
        return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
    endfunction

    function automatic logic is_acc(md_op_t op);
        return op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
    endfunction

    function automatic logic is_sub(md_op_t op);
        return op inside {MD_MSUB, MD_MSUBU};
    endfunction

    function automatic logic is_legal(md_op_t op);
`ifdef MULDIV_MADD_EN
        return 1'b1;
`else
        return !is_acc(op);
`endif
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_step.sv
// One combinational muldiv iteration: shift-add for multiply,
// restoring shift-subtract for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic             in_bit,
    input  logic             div,
    output logic [WIDTH:0]   res,
    output logic             take
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, operand};
        shifted = {acc, in_bit};
        diff    = {1'b0, shifted} - {2'b00, operand};
        if (div) begin
            take = ~diff[WIDTH+1];
            res  = take ? diff[WIDTH:0] : shifted;
        end else begin
            take = in_bit;
            res  = take ? sum : {1'b0, acc};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit feeding the decode-stage HI/LO registers.
// MULDIV_MADD_EN enables the accumulate ops (see muldiv_info::is_legal).
module hilo_muldiv_unit
    import muldiv_info::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             write_hi,
    output logic             write_lo,
    output logic [WIDTH-1:0] dest_hi_data,
    output logic [WIDTH-1:0] dest_lo_data
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    md_state_t        state, state_nx;
    logic [CW-1:0]    cnt;
    md_op_t           op_r;
    logic             neg_res, neg_rem;
    logic [WIDTH-1:0] hi_r, lo_r, opnd;
    logic [WIDTH-1:0] hi_l, lo_l;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_res;
    logic             step_take;
    logic             accept, sgn;

    assign sgn    = is_signed(op);
    assign accept = (state == IDLE) && start && !flush && is_legal(op);
    assign a_mag  = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign b_mag  = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    assign busy     = (state != IDLE);
    assign done     = (state == FIN) && !flush;
    assign write_hi = done;
    assign write_lo = done;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc     (hi_r),
        .operand (opnd),
        .in_bit  (is_div(op_r) ? lo_r[WIDTH-1] : lo_r[0]),
        .div     (is_div(op_r)),
        .res     (step_res),
        .take    (step_take)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Fixup runs in its own cycle after the last iteration, off the step path.
    always_comb begin
        logic [2*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] acc2;
        prod = {hi_r, lo_r};
        if (neg_res) prod = -prod;
        acc2 = {hi_l, lo_l};
        if (is_acc(op_r))
            prod = is_sub(op_r) ? acc2 - prod : acc2 + prod;
        {fix_hi, fix_lo} = prod;
        if (is_div(op_r)) begin
            fix_hi = neg_rem ? -hi_r : hi_r;
            fix_lo = neg_res ? -lo_r : lo_r;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            op_r         <= MD_MULT;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            hi_r         <= '0;
            lo_r         <= '0;
            opnd         <= '0;
            hi_l         <= '0;
            lo_l         <= '0;
            dest_hi_data <= '0;
            dest_lo_data <= '0;
        end else if (accept) begin
            cnt     <= '0;
            op_r    <= op;
            neg_res <= sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_rem <= sgn && rs_data[WIDTH-1];
            hi_r    <= '0;
            hi_l    <= hi_in;
            lo_l    <= lo_in;
            lo_r    <= is_div(op) ? a_mag : b_mag;
            opnd    <= is_div(op) ? b_mag : a_mag;
        end else if (state == RUN && !flush) begin
            if (cnt != LAST) begin
                cnt <= cnt + CW'(1);
                if (is_div(op_r)) begin
                    hi_r <= step_res[WIDTH-1:0];
                    lo_r <= {lo_r[WIDTH-2:0], step_take};
                end else begin
                    hi_r <= step_res[WIDTH:1];
                    lo_r <= {step_res[0], lo_r[WIDTH-1:1]};
                end
            end else begin
                dest_hi_data <= fix_hi;
                dest_lo_data <= fix_lo;
            end
        end
    end

endmodule
